rot_serializer: RTL

ROT_SERIALIZER -- requirements
Module: rot_serializer

---
 rtl/rot_serializer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/rot_serializer.sv
// ---------------------------------------------------------------------------
// rot_serializer
//
// Purpose:
//   Takes a byte from the barrel rotator output bus with a valid/ready
//   handshake and sends it out one bit per accepted serial transfer.
//   Bit order is chosen by LSB_FIRST. The first bit appears one cycle after
//   the byte is accepted. A new byte can be accepted during the transfer of
//   the final bit, so frames follow each other with no idle cycle.
//
// Configuration:
//   ROT_SERIALIZER_PARITY_EN - when defined, an even-parity bit (XOR of the
//                              eight data bits) follows the data bits, which
//                              gives 9-bit frames. When undefined, frames are
//                              8 bits and the design has no parity logic.
//
// Parameters:
//   LSB_FIRST  0 = send IN[7] first, 1 = send IN[0] first
//
// Ports:
//   CLK        in   clock; all state updates on the rising edge
//   RST        in   asynchronous, active-high reset
//   IN[7:0]    in   rotated byte from the barrel rotator
//   IN_VALID   in   IN holds a byte to transfer
//   IN_READY   out  the block accepts IN this cycle (combinational)
//   SER_READY  in   downstream accepts the current serial bit
//   SER_OUT    out  current serial bit (registered)
//   SER_VALID  out  SER_OUT carries a valid bit
//   SER_LAST   out  current bit is the final bit of the frame
//   BUSY       out  state is not IDLE
// ---------------------------------------------------------------------------
module rot_serializer #(
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [7:0] IN,
   input  logic       IN_VALID,
   output logic       IN_READY,
   input  logic       SER_READY,
   output logic       SER_OUT,
   output logic       SER_VALID,
   output logic       SER_LAST,
   output logic       BUSY
);

`ifdef ROT_SERIALIZER_PARITY_EN
   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY} state_t;
`else
   typedef enum logic [0:0] {S_IDLE, S_DATA} state_t;
`endif

   state_t     r_state;
   logic [7:0] r_shift;     // byte latched at acceptance, held for the whole frame
   logic [2:0] r_cnt;       // index of the bit currently on SER_OUT
   logic       r_ser_out;
   logic       r_ser_valid;
   logic       r_ser_last;

   logic       w_accept;
   logic       w_adv;
   logic       w_final;
   logic [2:0] w_nxt;
   logic       w_nxt_bit;
   logic       w_first_bit;

   // The bit currently on SER_OUT leaves on this edge.
   assign w_adv    = r_ser_valid & SER_READY;
   // The final bit of the frame leaves on this edge; a new byte may be taken.
   assign w_final  = r_ser_valid & r_ser_last & SER_READY;
   assign IN_READY = (r_state == S_IDLE) | w_final;
   assign w_accept = IN_VALID & IN_READY;

   // Bits are picked from the held byte by index rather than shifted out.
   // For MSB-first order the index is reversed: ~k equals 7-k for 3 bits.
   assign w_nxt       = r_cnt + 3'd1;
   assign w_nxt_bit   = r_shift[LSB_FIRST ? w_nxt : ~w_nxt];
   assign w_first_bit = LSB_FIRST ? IN[0] : IN[7];

   assign SER_OUT   = r_ser_out;
   assign SER_VALID = r_ser_valid;
   assign SER_LAST  = r_ser_last;
   assign BUSY      = (r_state != S_IDLE);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_shift     <= 8'h00;
         r_cnt       <= 3'd0;
         r_ser_out   <= 1'b0;
         r_ser_valid <= 1'b0;
         r_ser_last  <= 1'b0;
      end else if (w_accept) begin
         // Acceptance takes priority. It happens in IDLE or while the final
         // bit leaves, so that is the back-to-back path too.
         r_state     <= S_DATA;
         r_shift     <= IN;
         r_cnt       <= 3'd0;
         r_ser_out   <= w_first_bit;
         r_ser_valid <= 1'b1;
         r_ser_last  <= 1'b0;
      end else if (w_adv) begin
         case (r_state)
            S_DATA: begin
               if (r_cnt != 3'd7) begin
                  r_cnt     <= w_nxt;
                  r_ser_out <= w_nxt_bit;
`ifdef ROT_SERIALIZER_PARITY_EN
                  r_ser_last <= 1'b0;
`else
                  r_ser_last <= (w_nxt == 3'd7);
`endif
               end else begin
`ifdef ROT_SERIALIZER_PARITY_EN
                  // The eighth data bit has left; the parity bit ends the frame.
                  r_state    <= S_PARITY;
                  r_cnt      <= 3'd0;
                  r_ser_out  <= ^r_shift;
                  r_ser_last <= 1'b1;
`else
                  r_state     <= S_IDLE;
                  r_cnt       <= 3'd0;
                  r_ser_out   <= 1'b0;
                  r_ser_valid <= 1'b0;
                  r_ser_last  <= 1'b0;
`endif
               end
            end
            default: begin
               // End of the frame with no new byte waiting.
               r_state     <= S_IDLE;
               r_cnt       <= 3'd0;
               r_ser_out   <= 1'b0;
               r_ser_valid <= 1'b0;
               r_ser_last  <= 1'b0;
            end
         endcase
      end
   end

endmodule
